// File: rtl/fir_hls_mul_pipe.sv
// ---------------------------------------------------------------------------
// fir_hls_mul_pipe
//
// Pipelined signed multiplier used by the FIR datapath. It multiplies a
// signed din0 by din1, which is either signed or zero-extended depending on
// DIN1_SIGNED. The product is kept at full precision and then optionally
// rounded and right-shifted (round half toward +inf). The result is then
// saturated or wrapped into DOUT_WIDTH bits, and ovf flags every result that
// did not fit.
//
// The pipeline has NUM_STAGE register stages, each with a valid bit, and a
// ready/valid handshake on both sides. The stall is global: every stage
// advances together when the output slot is empty or is being consumed.
//
// Parameters
//   DIN0_WIDTH  width of signed operand din0                    (2..32)
//   DIN1_WIDTH  width of operand din1                           (2..32)
//   DIN1_SIGNED 0: din1 unsigned, 1: din1 signed
//   DOUT_WIDTH  width of signed result dout                     (2..64)
//   NUM_STAGE   latency in cycles                               (1..8)
//   SHIFT       rounding right-shift applied to the product
//   SATURATE    1: saturate on overflow, 0: two's-complement wrap
//
// Ports
//   ap_clk    in   clock, rising edge
//   ap_rst    in   synchronous active-high reset
//   din_vld   in   operands valid
//   din_rdy   out  operands accepted this cycle if din_vld is high
//   din0      in   signed multiplicand
//   din1      in   multiplier
//   dout_vld  out  dout/ovf valid
//   dout_rdy  in   downstream consumes dout this cycle
//   dout      out  rounded, saturated or wrapped product
//   ovf       out  result did not fit DOUT_WIDTH
// ---------------------------------------------------------------------------
module fir_hls_mul_pipe #(
  parameter int DIN0_WIDTH  = 19,
  parameter int DIN1_WIDTH  = 8,
  parameter int DIN1_SIGNED = 0,
  parameter int DOUT_WIDTH  = 26,
  parameter int NUM_STAGE   = 3,
  parameter int SHIFT       = 0,
  parameter int SATURATE    = 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  din_vld,
  output logic                  din_rdy,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  dout_vld,
  input  logic                  dout_rdy,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  ovf
);

  // Full product width. A signed N-bit value times an M-bit value (signed or
  // unsigned) always fits in N+M signed bits.
  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
  // The rounding add is carried one bit wider so it cannot overflow.
  localparam int SW = PW + 1;
  // Width of the rounded/shifted result R before fitting to DOUT_WIDTH.
  localparam int RW = (SHIFT > 0) ? SW - SHIFT : PW;
  // Rounding constant 2^(SHIFT-1). It is zero when there is no shift.
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [SW-1:0] RND = (SHIFT > 0) ? (SW'(1) << RND_POS) : '0;

  // -------------------------------------------------------------------------
  // Handshake. The only thing that can stop the pipeline is a valid result
  // that is not being taken. din_rdy therefore depends on dout_vld (a
  // register) and on dout_rdy only, and never on din_vld.
  // -------------------------------------------------------------------------
  logic adv;
  logic acc;

  assign adv     = !dout_vld || dout_rdy;
  assign din_rdy = adv;
  assign acc     = din_vld && adv;

  // -------------------------------------------------------------------------
  // Operand extension and exact product
  // -------------------------------------------------------------------------
  logic signed [DIN1_WIDTH:0] din1_x;
  logic signed [PW-1:0]       a_x;
  logic signed [PW-1:0]       b_x;
  logic signed [PW-1:0]       p_in;

  assign din1_x = (DIN1_SIGNED != 0) ? {din1[DIN1_WIDTH-1], din1} : {1'b0, din1};
  // Both operands are sign-extended to the full product width first, so the
  // multiply is evaluated at PW bits and no product bit is lost.
  assign a_x    = PW'($signed(din0));
  assign b_x    = PW'(din1_x);
  assign p_in   = a_x * b_x;

  // -------------------------------------------------------------------------
  // Round, shift and fit. p_src is the product feeding the result logic. It
  // comes straight from the multiplier in a single-stage pipe, and from the
  // product register otherwise.
  // -------------------------------------------------------------------------
  logic signed [PW-1:0]     p_src;
  logic [SW-1:0]            sum_w;
  logic signed [RW-1:0]     r_w;
  logic [DOUT_WIDTH-1:0]    res_dout;
  logic                     res_ovf;

  assign sum_w = {p_src[PW-1], p_src} + RND;
  // The arithmetic shift keeps the sign. The bits above RW are just copies
  // of the sign bit, so dropping them loses nothing.
  assign r_w   = RW'($signed(sum_w) >>> SHIFT);

  if (DOUT_WIDTH >= RW) begin : g_fit
    // Every possible R fits, so overflow cannot happen.
    assign res_dout = DOUT_WIDTH'(r_w);
    assign res_ovf  = 1'b0;
  end else begin : g_range
    // R fits when all bits from the output sign bit upward are equal.
    localparam int HW = RW - DOUT_WIDTH + 1;
    logic [HW-1:0] hi;
    logic          fits;

    assign hi   = r_w[RW-1:DOUT_WIDTH-1];
    assign fits = (&hi) | (~|hi);

    always_comb begin
      // NOTE: both outputs get a default before any branch. This way no path
      // through the block leaves them unassigned, and no latch is inferred.
      res_dout = r_w[DOUT_WIDTH-1:0];
      res_ovf  = 1'b0;
      if (!fits) begin
        res_ovf = 1'b1;
        if (SATURATE != 0) begin
          res_dout = r_w[RW-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                               : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Pipeline stages
  // -------------------------------------------------------------------------
  if (NUM_STAGE == 1) begin : g_one
    // A single stage: multiply, round and fit in one cycle into the output
    // register.
    logic                  vld_q;
    logic [DOUT_WIDTH-1:0] dout_q;
    logic                  ovf_q;

    assign p_src = p_in;

    always_ff @(posedge ap_clk) begin
      // NOTE: the data registers are reset along with the valid bits, because
      // dout and ovf must read zero after reset. Otherwise only the valid bits
      // would need a reset.
      if (ap_rst) begin
        // NOTE: every state update in this block is non-blocking, so all
        // registers sample their pre-edge values together.
        vld_q  <= 1'b0;
        dout_q <= '0;
        ovf_q  <= 1'b0;
      end else if (adv) begin
        vld_q <= acc;
        // Data moves only with a valid transfer. Operands on idle cycles
        // never reach the output.
        if (acc) begin
          dout_q <= res_dout;
          ovf_q  <= res_ovf;
        end
      end
    end

    assign dout_vld = vld_q;
    assign dout     = dout_q;
    assign ovf      = ovf_q;

  end else begin : g_multi
    // Stage 0 holds the exact product. Stage 1 holds the fitted result.
    // Stages 2..NUM_STAGE-1 only delay it.
    logic [NUM_STAGE-1:0]  vld_q;
    logic signed [PW-1:0]  p_q;
    logic [DOUT_WIDTH:0]   stg_q [1:NUM_STAGE-1];  // {ovf, dout}

    assign p_src = p_q;

    always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
        vld_q <= '0;
        p_q   <= '0;
        for (int k = 1; k < NUM_STAGE; k++) begin
          stg_q[k] <= '0;
        end
      end else if (adv) begin
        // Bubbles shift through as invalid stages and are never collapsed.
        // This keeps the latency fixed.
        vld_q <= {vld_q[NUM_STAGE-2:0], acc};
        if (acc) begin
          p_q <= p_in;
        end
        if (vld_q[0]) begin
          stg_q[1] <= {res_ovf, res_dout};
        end
        for (int k = 2; k < NUM_STAGE; k++) begin
          if (vld_q[k-1]) begin
            stg_q[k] <= stg_q[k-1];
          end
        end
      end
    end

    assign dout_vld = vld_q[NUM_STAGE-1];
    assign dout     = stg_q[NUM_STAGE-1][DOUT_WIDTH-1:0];
    assign ovf      = stg_q[NUM_STAGE-1][DOUT_WIDTH];
  end

endmodule

// File: tb/tb_fir_hls_mul_pipe.sv
// ---------------------------------------------------------------------------
// tb_fir_hls_mul_pipe
//
// Directed bench for fir_hls_mul_pipe. Four instances share the same input
// stimulus:
//   u_def  default parameters (saturate, 3 stages, 26-bit result)
//   u_wrap SATURATE=0
//   u_shf  SHIFT=4
//   u_sgn  DIN1_SIGNED=1, NUM_STAGE=1, DOUT_WIDTH=12
// All expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_fir_hls_mul_pipe;

  logic        ap_clk;
  logic        ap_rst;
  logic        din_vld;
  logic        dout_rdy;
  logic [18:0] din0;
  logic [7:0]  din1;

  logic               rdy_def, vld_def, ovf_def;
  logic signed [25:0] dout_def;
  logic               rdy_wrap, vld_wrap, ovf_wrap;
  logic signed [25:0] dout_wrap;
  logic               rdy_shf, vld_shf, ovf_shf;
  logic signed [25:0] dout_shf;
  logic               rdy_sgn, vld_sgn, ovf_sgn;
  logic signed [11:0] dout_sgn;

  int checks   = 0;
  int failures = 0;

  fir_hls_mul_pipe u_def (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .din_vld(din_vld), .din_rdy(rdy_def),
    .din0(din0), .din1(din1), .dout_vld(vld_def), .dout_rdy(dout_rdy),
    .dout(dout_def), .ovf(ovf_def)
  );

  fir_hls_mul_pipe #(.SATURATE(0)) u_wrap (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .din_vld(din_vld), .din_rdy(rdy_wrap),
    .din0(din0), .din1(din1), .dout_vld(vld_wrap), .dout_rdy(dout_rdy),
    .dout(dout_wrap), .ovf(ovf_wrap)
  );

  fir_hls_mul_pipe #(.SHIFT(4)) u_shf (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .din_vld(din_vld), .din_rdy(rdy_shf),
    .din0(din0), .din1(din1), .dout_vld(vld_shf), .dout_rdy(dout_rdy),
    .dout(dout_shf), .ovf(ovf_shf)
  );

  fir_hls_mul_pipe #(.DIN1_SIGNED(1), .NUM_STAGE(1), .DOUT_WIDTH(12)) u_sgn (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .din_vld(din_vld), .din_rdy(rdy_sgn),
    .din0(din0), .din1(din1), .dout_vld(vld_sgn), .dout_rdy(dout_rdy),
    .dout(dout_sgn), .ovf(ovf_sgn)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Move to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // One transfer, then idle until it reaches the output of the 3-stage
  // instances (NUM_STAGE cycles after it was accepted).
  task automatic drive_one(input int a, input int b);
    din0    = 19'(a);
    din1    = 8'(b);
    din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    ap_rst   = 1'b1;
    din_vld  = 1'b0;
    dout_rdy = 1'b1;
    din0     = '0;
    din1     = '0;
    tick();
    tick();
    ap_rst = 1'b0;
    checks++;
    if (vld_def !== 1'b0 || dout_def !== 26'sd0 || ovf_def !== 1'b0) begin
      failures++;
      $display("FAIL reset_def: vld=%0b dout=%0d ovf=%0b exp 0/0/0", vld_def, dout_def, ovf_def);
    end
    checks++;
    if (vld_sgn !== 1'b0 || dout_sgn !== 12'sd0 || ovf_sgn !== 1'b0) begin
      failures++;
      $display("FAIL reset_sgn: vld=%0b dout=%0d ovf=%0b exp 0/0/0", vld_sgn, dout_sgn, ovf_sgn);
    end
    tick();
    checks++;
    if (rdy_def !== 1'b1) begin
      failures++;
      $display("FAIL reset_rdy: din_rdy=%0b exp 1", rdy_def);
    end
  endtask

  task automatic test_basic();
    din0    = 19'sd1000;
    din1    = 8'd200;
    din_vld = 1'b1;
    tick();
    // Operands on idle cycles are garbage and must not matter.
    din_vld = 1'b0;
    din0    = '1;
    din1    = '1;
    checks++;
    if (vld_def !== 1'b0) begin
      failures++;
      $display("FAIL latency_n1: dout_vld=%0b exp 0", vld_def);
    end
    tick();
    checks++;
    if (vld_def !== 1'b0) begin
      failures++;
      $display("FAIL latency_n2: dout_vld=%0b exp 0", vld_def);
    end
    tick();
    checks++;
    if (vld_def !== 1'b1 || dout_def !== 26'sd200000 || ovf_def !== 1'b0) begin
      failures++;
      $display("FAIL basic_def: vld=%0b dout=%0d ovf=%0b exp 1/200000/0", vld_def, dout_def, ovf_def);
    end
    checks++;
    if (vld_shf !== 1'b1 || dout_shf !== 26'sd12500 || ovf_shf !== 1'b0) begin
      failures++;
      $display("FAIL basic_shf: vld=%0b dout=%0d ovf=%0b exp 1/12500/0", vld_shf, dout_shf, ovf_shf);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (vld_def !== 1'b0) begin
        failures++;
        $display("FAIL idle_vld[%0d]: dout_vld=%0b exp 0", i, vld_def);
      end
    end
  endtask

  task automatic test_saturate();
    int a[2]     = '{-262144, 262143};
    int e_def[2] = '{-33554432, 33554431};
    int e_wr[2]  = '{262144, -262399};
    int e_shf[2] = '{-4177920, 4177904};
    for (int i = 0; i < 2; i++) begin
      drive_one(a[i], 255);
      checks++;
      if (vld_def !== 1'b1 || dout_def !== 26'(e_def[i]) || ovf_def !== 1'b1) begin
        failures++;
        $display("FAIL sat_def[%0d]: vld=%0b dout=%0d ovf=%0b exp 1/%0d/1", i, vld_def, dout_def, ovf_def, e_def[i]);
      end
      checks++;
      if (vld_wrap !== 1'b1 || dout_wrap !== 26'(e_wr[i]) || ovf_wrap !== 1'b1) begin
        failures++;
        $display("FAIL wrap[%0d]: vld=%0b dout=%0d ovf=%0b exp 1/%0d/1", i, vld_wrap, dout_wrap, ovf_wrap, e_wr[i]);
      end
      checks++;
      if (dout_shf !== 26'(e_shf[i]) || ovf_shf !== 1'b0) begin
        failures++;
        $display("FAIL sat_shf[%0d]: dout=%0d ovf=%0b exp %0d/0", i, dout_shf, ovf_shf, e_shf[i]);
      end
    end
  endtask

  task automatic test_round();
    int a[5] = '{7, -7, -8, 8, -24};
    int b[5] = '{3, 3, 1, 1, 1};
    int e[5] = '{1, -1, 0, 1, -1};
    for (int i = 0; i < 5; i++) begin
      drive_one(a[i], b[i]);
      checks++;
      if (vld_shf !== 1'b1 || dout_shf !== 26'(e[i]) || ovf_shf !== 1'b0) begin
        failures++;
        $display("FAIL round[%0d]: vld=%0b dout=%0d ovf=%0b exp 1/%0d/0", i, vld_shf, dout_shf, ovf_shf, e[i]);
      end
    end
  endtask

  task automatic test_signed();
    int a[6]   = '{5, 1000, -1000, 2047, -2048, 2048};
    int b[6]   = '{255, 100, 100, 1, 1, 1};
    int e[6]   = '{-5, 2047, -2048, 2047, -2048, 2047};
    logic o[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      din0    = 19'(a[i]);
      din1    = 8'(b[i]);
      din_vld = 1'b1;
      tick();
      din_vld = 1'b0;
      checks++;
      if (vld_sgn !== 1'b1 || dout_sgn !== 12'(e[i]) || ovf_sgn !== o[i]) begin
        failures++;
        $display("FAIL signed[%0d]: vld=%0b dout=%0d ovf=%0b exp 1/%0d/%0b", i, vld_sgn, dout_sgn, ovf_sgn, e[i], o[i]);
      end
      if (i == 0) begin
        // The same operands on the unsigned instance give 5*255.
        tick();
        tick();
        checks++;
        if (vld_def !== 1'b1 || dout_def !== 26'sd1275) begin
          failures++;
          $display("FAIL unsigned_din1: vld=%0b dout=%0d exp 1/1275", vld_def, dout_def);
        end
      end
    end
    tick();
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    int a[8] = '{1, 2, -5, 100, -1000, 12345, 0, -3};
    int b[8] = '{1, 3, 10, 100, 7, 2, 255, 255};
    int e[8] = '{1, 6, -50, 10000, -7000, 24690, 0, -765};
    int sent = 0;
    int recv = 0;
    logic prev_stall = 1'b0;
    logic signed [25:0] prev_dout = '0;
    for (int c = 0; c < 40 && recv < 8; c++) begin
      dout_rdy = !(c >= 4 && c <= 6);
      din_vld  = (sent < 8);
      din0     = 19'(a[sent % 8]);
      din1     = 8'(b[sent % 8]);
      #1;
      if (c >= 4 && c <= 6) begin
        checks++;
        if (rdy_def !== 1'b0) begin
          failures++;
          $display("FAIL b2b_rdy_low[c%0d]: din_rdy=%0b exp 0", c, rdy_def);
        end
      end
      if (prev_stall) begin
        checks++;
        if (vld_def !== 1'b1 || dout_def !== prev_dout) begin
          failures++;
          $display("FAIL b2b_stable[c%0d]: vld=%0b dout=%0d exp 1/%0d", c, vld_def, dout_def, prev_dout);
        end
      end
      if (vld_def && dout_rdy) begin
        checks++;
        if (dout_def !== 26'(e[recv])) begin
          failures++;
          $display("FAIL b2b_data[%0d]: dout=%0d exp %0d", recv, dout_def, e[recv]);
        end
        recv++;
      end
      prev_stall = vld_def && !dout_rdy;
      prev_dout  = dout_def;
      if (din_vld && rdy_def) sent++;
      tick();
    end
    din_vld  = 1'b0;
    dout_rdy = 1'b1;
    checks++;
    if (recv !== 8) begin
      failures++;
      $display("FAIL b2b_count: received=%0d exp 8", recv);
    end
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset_midflight();
    // Two transfers are in flight when the reset hits.
    dout_rdy = 1'b1;
    din0 = 19'sd3;
    din1 = 8'd4;
    din_vld = 1'b1;
    tick();
    din0 = 19'sd5;
    din1 = 8'd6;
    tick();
    din_vld = 1'b0;
    ap_rst  = 1'b1;
    tick();
    ap_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (vld_def !== 1'b0 || dout_def !== 26'sd0 || ovf_def !== 1'b0) begin
        failures++;
        $display("FAIL rst_flight[%0d]: vld=%0b dout=%0d ovf=%0b exp 0/0/0", i, vld_def, dout_def, ovf_def);
      end
      tick();
    end
    din0 = 19'sd9;
    din1 = 8'd9;
    din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    tick();
    checks++;
    if (vld_def !== 1'b0) begin
      failures++;
      $display("FAIL rst_relat_early: dout_vld=%0b exp 0", vld_def);
    end
    tick();
    checks++;
    if (vld_def !== 1'b1 || dout_def !== 26'sd81) begin
      failures++;
      $display("FAIL rst_relat: vld=%0b dout=%0d exp 1/81", vld_def, dout_def);
    end
    tick();

    // Reset while the output is stalled.
    dout_rdy = 1'b0;
    din0 = 19'sd11;
    din1 = 8'd11;
    din_vld = 1'b1;
    tick();
    din0 = 19'sd2;
    din1 = 8'd2;
    tick();
    din_vld = 1'b0;
    tick();
    tick();
    checks++;
    if (vld_def !== 1'b1 || dout_def !== 26'sd121 || rdy_def !== 1'b0) begin
      failures++;
      $display("FAIL stall_hold: vld=%0b dout=%0d rdy=%0b exp 1/121/0", vld_def, dout_def, rdy_def);
    end
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    checks++;
    if (vld_def !== 1'b0 || dout_def !== 26'sd0 || rdy_def !== 1'b1) begin
      failures++;
      $display("FAIL rst_stall: vld=%0b dout=%0d rdy=%0b exp 0/0/1", vld_def, dout_def, rdy_def);
    end
    dout_rdy = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (vld_def !== 1'b0) begin
      failures++;
      $display("FAIL rst_stall_drop: dout_vld=%0b exp 0", vld_def);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_round();
    test_signed();
    test_back_to_back();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
